// File: rtl/cash_dispenser.sv
// cash_dispenser: note dispenser controller with greedy withdrawal planning.
// The requested amount is validated, then a plan is built one note per cycle
// against shadow copies of the stock. Notes are ejected only after the whole
// plan succeeds, so a short stock never touches the real counters.
// Optional feature macro: DISP_ABORT_EN adds the disp_abort input, which cancels
// a transaction in CHECK, PLAN, DISPENSE or GAP with err_code 11.

module cash_dispenser #(
    parameter int INIT_2000 = 50,
    parameter int INIT_500  = 100,
    parameter int INIT_100  = 200,
    parameter int MAX_AMT   = 20000,
    parameter int PULSE_GAP = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_req,
    input  logic [20:0] amount,
    input  logic        refill,
`ifdef DISP_ABORT_EN
    input  logic        disp_abort,
`endif
    output logic        disp_busy,
    output logic        note_pulse,
    output logic [1:0]  note_type,
    output logic        disp_done,
    output logic        disp_error,
    output logic [1:0]  err_code,
    output logic [9:0]  cnt_2000,
    output logic [9:0]  cnt_500,
    output logic [9:0]  cnt_100
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PLAN,
        S_DISPENSE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [20:0] V2000    = 21'd2000;
    localparam logic [20:0] V500     = 21'd500;
    localparam logic [20:0] V100     = 21'd100;
    localparam logic [20:0] MAX_A    = 21'(MAX_AMT);
    localparam logic [9:0]  I2000    = 10'(INIT_2000);
    localparam logic [9:0]  I500     = 10'(INIT_500);
    localparam logic [9:0]  I100     = 10'(INIT_100);
    localparam logic [15:0] GAP_LAST = 16'(PULSE_GAP - 1);

    localparam logic [1:0] T_100  = 2'b00;
    localparam logic [1:0] T_500  = 2'b01;
    localparam logic [1:0] T_2000 = 2'b10;

    localparam logic [1:0] E_INVALID = 2'b01;
    localparam logic [1:0] E_SHORT   = 2'b10;
    localparam logic [1:0] E_ABORT   = 2'b11;

    state_t       state;
    state_t       state_next;

    logic [20:0]  rem;
    logic [9:0]   sh_2000;
    logic [9:0]   sh_500;
    logic [9:0]   sh_100;
    logic [9:0]   p_2000;
    logic [9:0]   p_500;
    logic [9:0]   p_100;
    logic [15:0]  gap_cnt;

    logic         abort_req;
    logic         latch_req;
    logic         do_refill;
    logic         load_plan;
    logic         take_2000;
    logic         take_500;
    logic         take_100;
    logic         pop_2000;
    logic         pop_500;
    logic         pop_100;
    logic         clear_plan;
    logic         err_set;
    logic [1:0]   err_val;
    logic         gap_load;
    logic         gap_dec;
    logic         plan_left;

`ifdef DISP_ABORT_EN
    assign abort_req = disp_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign plan_left = (p_2000 != 10'd0) || (p_500 != 10'd0) || (p_100 != 10'd0);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the strobes and datapath controls for each state.
    always_comb begin
        state_next = state;
        disp_busy  = (state != S_IDLE);
        note_pulse = 1'b0;
        note_type  = T_100;
        disp_done  = 1'b0;
        disp_error = 1'b0;
        latch_req  = 1'b0;
        do_refill  = 1'b0;
        load_plan  = 1'b0;
        take_2000  = 1'b0;
        take_500   = 1'b0;
        take_100   = 1'b0;
        pop_2000   = 1'b0;
        pop_500    = 1'b0;
        pop_100    = 1'b0;
        clear_plan = 1'b0;
        err_set    = 1'b0;
        err_val    = 2'b00;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;

        case (state)
            S_IDLE: begin
                if (disp_req) begin
                    latch_req  = 1'b1;
                    state_next = S_CHECK;
                end else if (refill) begin
                    do_refill = 1'b1;
                end
            end

            S_CHECK: begin
                if (abort_req) begin
                    err_set    = 1'b1;
                    err_val    = E_ABORT;
                    state_next = S_ERROR;
                end else if ((rem == 21'd0) || ((rem % V100) != 21'd0) || (rem > MAX_A)) begin
                    err_set    = 1'b1;
                    err_val    = E_INVALID;
                    state_next = S_ERROR;
                end else begin
                    load_plan  = 1'b1;
                    state_next = S_PLAN;
                end
            end

            S_PLAN: begin
                if (abort_req) begin
                    clear_plan = 1'b1;
                    err_set    = 1'b1;
                    err_val    = E_ABORT;
                    state_next = S_ERROR;
                end else if (rem == 21'd0) begin
                    state_next = S_DISPENSE;
                end else if ((rem >= V2000) && (sh_2000 != 10'd0)) begin
                    take_2000 = 1'b1;
                end else if ((rem >= V500) && (sh_500 != 10'd0)) begin
                    take_500 = 1'b1;
                end else if ((rem >= V100) && (sh_100 != 10'd0)) begin
                    take_100 = 1'b1;
                end else begin
                    err_set    = 1'b1;
                    err_val    = E_SHORT;
                    state_next = S_ERROR;
                end
            end

            S_DISPENSE: begin
                if (p_2000 != 10'd0) begin
                    note_pulse = 1'b1;
                    note_type  = T_2000;
                    pop_2000   = 1'b1;
                end else if (p_500 != 10'd0) begin
                    note_pulse = 1'b1;
                    note_type  = T_500;
                    pop_500    = 1'b1;
                end else if (p_100 != 10'd0) begin
                    note_pulse = 1'b1;
                    note_type  = T_100;
                    pop_100    = 1'b1;
                end
                if (abort_req) begin
                    clear_plan = 1'b1;
                    err_set    = 1'b1;
                    err_val    = E_ABORT;
                    state_next = S_ERROR;
                end else begin
                    gap_load   = 1'b1;
                    state_next = S_GAP;
                end
            end

            S_GAP: begin
                if (abort_req) begin
                    clear_plan = 1'b1;
                    err_set    = 1'b1;
                    err_val    = E_ABORT;
                    state_next = S_ERROR;
                end else if (gap_cnt == 16'd0) begin
                    state_next = plan_left ? S_DISPENSE : S_DONE;
                end else begin
                    gap_dec = 1'b1;
                end
            end

            S_DONE: begin
                disp_done  = 1'b1;
                state_next = S_IDLE;
            end

            S_ERROR: begin
                disp_error = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Remaining amount: captured at request time, reduced as notes are planned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= 21'd0;
        end else if (latch_req) begin
            rem <= amount;
        end else if (take_2000) begin
            rem <= rem - V2000;
        end else if (take_500) begin
            rem <= rem - V500;
        end else if (take_100) begin
            rem <= rem - V100;
        end
    end

    // Shadow stock used only while planning, so the real counters stay intact on failure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_2000 <= 10'd0;
            sh_500  <= 10'd0;
            sh_100  <= 10'd0;
        end else if (load_plan) begin
            sh_2000 <= cnt_2000;
            sh_500  <= cnt_500;
            sh_100  <= cnt_100;
        end else begin
            if (take_2000) sh_2000 <= sh_2000 - 10'd1;
            if (take_500)  sh_500  <= sh_500  - 10'd1;
            if (take_100)  sh_100  <= sh_100  - 10'd1;
        end
    end

    // Plan counts: built up in PLAN, consumed one note per DISPENSE, wiped on abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_2000 <= 10'd0;
            p_500  <= 10'd0;
            p_100  <= 10'd0;
        end else if (load_plan || clear_plan) begin
            p_2000 <= 10'd0;
            p_500  <= 10'd0;
            p_100  <= 10'd0;
        end else begin
            if (take_2000)     p_2000 <= p_2000 + 10'd1;
            else if (pop_2000) p_2000 <= p_2000 - 10'd1;
            if (take_500)      p_500  <= p_500  + 10'd1;
            else if (pop_500)  p_500  <= p_500  - 10'd1;
            if (take_100)      p_100  <= p_100  + 10'd1;
            else if (pop_100)  p_100  <= p_100  - 10'd1;
        end
    end

    // Real inventory: reloaded on refill, decremented only when a note is ejected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_2000 <= I2000;
            cnt_500  <= I500;
            cnt_100  <= I100;
        end else if (do_refill) begin
            cnt_2000 <= I2000;
            cnt_500  <= I500;
            cnt_100  <= I100;
        end else begin
            if (pop_2000) cnt_2000 <= cnt_2000 - 10'd1;
            if (pop_500)  cnt_500  <= cnt_500  - 10'd1;
            if (pop_100)  cnt_100  <= cnt_100  - 10'd1;
        end
    end

    // Error code is held after a failure and only cleared by the next request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_code <= 2'b00;
        end else if (latch_req) begin
            err_code <= 2'b00;
        end else if (err_set) begin
            err_code <= err_val;
        end
    end

    // Gap timer: loaded on each pulse, counts down the idle cycles before the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= 16'd0;
        end else if (gap_load) begin
            gap_cnt <= GAP_LAST;
        end else if (gap_dec) begin
            gap_cnt <= gap_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_cash_dispenser.sv
// tb_cash_dispenser: directed self-checking bench for cash_dispenser.
// Two instances share clock and reset: one with default stock, one with a
// small stock (2000:1, 500:4, 100:2) to reach shortage cases quickly.
// Define DISP_ABORT_EN to also exercise the abort input.

module tb_cash_dispenser;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] amount;
    logic        a_req, a_refill, b_req, b_refill;
    logic        disp_abort;

    logic        a_busy, a_pulse, a_done, a_error;
    logic [1:0]  a_type, a_err;
    logic [9:0]  a_c2000, a_c500, a_c100;
    logic        b_busy, b_pulse, b_done, b_error;
    logic [1:0]  b_type, b_err;
    logic [9:0]  b_c2000, b_c500, b_c100;

    logic        sel;
    logic        mon_busy, mon_pulse, mon_done, mon_error;
    logic [1:0]  mon_type, mon_err;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    int          n_pulses;
    logic [1:0]  plog [0:15];
    int          gap_min, gap_max, last_pulse;
    bit          got_done, got_error, timed_out, both_high, bad_type, busy_drop;
    logic [1:0]  last_err;

    always #5 clk = ~clk;

    cash_dispenser dut_a (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (a_req),
        .amount     (amount),
        .refill     (a_refill),
`ifdef DISP_ABORT_EN
        .disp_abort (disp_abort),
`endif
        .disp_busy  (a_busy),
        .note_pulse (a_pulse),
        .note_type  (a_type),
        .disp_done  (a_done),
        .disp_error (a_error),
        .err_code   (a_err),
        .cnt_2000   (a_c2000),
        .cnt_500    (a_c500),
        .cnt_100    (a_c100)
    );

    cash_dispenser #(
        .INIT_2000 (1),
        .INIT_500  (4),
        .INIT_100  (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (b_req),
        .amount     (amount),
        .refill     (b_refill),
`ifdef DISP_ABORT_EN
        .disp_abort (1'b0),
`endif
        .disp_busy  (b_busy),
        .note_pulse (b_pulse),
        .note_type  (b_type),
        .disp_done  (b_done),
        .disp_error (b_error),
        .err_code   (b_err),
        .cnt_2000   (b_c2000),
        .cnt_500    (b_c500),
        .cnt_100    (b_c100)
    );

    assign mon_busy  = sel ? b_busy  : a_busy;
    assign mon_pulse = sel ? b_pulse : a_pulse;
    assign mon_done  = sel ? b_done  : a_done;
    assign mon_error = sel ? b_error : a_error;
    assign mon_type  = sel ? b_type  : a_type;
    assign mon_err   = sel ? b_err   : a_err;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Runs one request on the selected instance and records what it did.
    task automatic apply_stimulus(input bit which, input logic [20:0] amt, input bit with_refill, input int abort_after);
        sel        = which;
        n_pulses   = 0;
        gap_min    = 9999;
        gap_max    = 0;
        last_pulse = 0;
        got_done   = 0;
        got_error  = 0;
        both_high  = 0;
        bad_type   = 0;
        busy_drop  = 0;
        last_err   = 2'b00;
        for (int i = 0; i < 16; i++) plog[i] = 2'b11;
        @(negedge clk);
        amount = amt;
        if (which) begin
            b_req = 1'b1; b_refill = with_refill;
        end else begin
            a_req = 1'b1; a_refill = with_refill;
        end
        @(negedge clk);
        a_req = 1'b0; a_refill = 1'b0; b_req = 1'b0; b_refill = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mon_done && mon_error) both_high = 1;
            if (!mon_pulse && (mon_type != 2'b00)) bad_type = 1;
            if (!mon_busy) busy_drop = 1;
            if (mon_pulse) begin
                if (n_pulses < 16) plog[n_pulses] = mon_type;
                if (n_pulses > 0) begin
                    if (cyc - last_pulse - 1 < gap_min) gap_min = cyc - last_pulse - 1;
                    if (cyc - last_pulse - 1 > gap_max) gap_max = cyc - last_pulse - 1;
                end
                last_pulse = cyc;
                n_pulses++;
            end
            if (mon_done || mon_error) begin
                got_done  = mon_done;
                got_error = mon_error;
                last_err  = mon_err;
                break;
            end
            disp_abort = (abort_after > 0) && (n_pulses == abort_after) && (cyc == last_pulse + 1);
            @(negedge clk);
        end
        disp_abort = 1'b0;
        timed_out = !(got_done || got_error);
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input bit exp_done, input logic [1:0] exp_err, input int exp_n);
        check_output({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check_output({tag, "_done"}, 32'(got_done), 32'(exp_done));
        check_output({tag, "_error"}, 32'(got_error), 32'(!exp_done));
        check_output({tag, "_errcode"}, 32'(last_err), 32'(exp_err));
        check_output({tag, "_npulses"}, 32'(n_pulses), 32'(exp_n));
        check_output({tag, "_both"}, 32'(both_high), 32'd0);
        check_output({tag, "_type_idle"}, 32'(bad_type), 32'd0);
        check_output({tag, "_busy"}, 32'(busy_drop), 32'd0);
        check_output({tag, "_busy_after"}, 32'(mon_busy), 32'd0);
    endtask

    task automatic check_counts(input string tag, input bit which, input int e2000, input int e500, input int e100);
        check_output({tag, "_cnt2000"}, 32'(which ? b_c2000 : a_c2000), 32'(e2000));
        check_output({tag, "_cnt500"},  32'(which ? b_c500  : a_c500),  32'(e500));
        check_output({tag, "_cnt100"},  32'(which ? b_c100  : a_c100),  32'(e100));
    endtask

    task automatic do_refill(input bit which);
        @(negedge clk);
        if (which) b_refill = 1'b1; else a_refill = 1'b1;
        @(negedge clk);
        a_refill = 1'b0; b_refill = 1'b0;
    endtask

    initial begin
        int  seen;
        bit  strobe;
        reset      = 1'b0;
        amount     = 21'd0;
        a_req      = 1'b0; a_refill = 1'b0;
        b_req      = 1'b0; b_refill = 1'b0;
        disp_abort = 1'b0;
        sel        = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_busy",  32'(a_busy),  32'd0);
        check_output("rst_pulse", 32'(a_pulse), 32'd0);
        check_output("rst_type",  32'(a_type),  32'd0);
        check_output("rst_done",  32'(a_done),  32'd0);
        check_output("rst_error", 32'(a_error), 32'd0);
        check_output("rst_err",   32'(a_err),   32'd0);
        check_counts("rst_a", 1'b0, 50, 100, 200);
        check_counts("rst_b", 1'b1, 1, 4, 2);
        reset = 1'b1;
        @(negedge clk);
        check_counts("rel_a", 1'b0, 50, 100, 200);

        // 2600: 2000, 500, 100 with three idle cycles between pulses
        $display("[TB] step: 2600 with default stock");
        apply_stimulus(1'b0, 21'd2600, 1'b0, 0);
        check_result("t2600", 1'b1, 2'b00, 3);
        check_output("t2600_p0", 32'(plog[0]), 32'd2);
        check_output("t2600_p1", 32'(plog[1]), 32'd1);
        check_output("t2600_p2", 32'(plog[2]), 32'd0);
        check_output("t2600_gapmin", 32'(gap_min), 32'd3);
        check_output("t2600_gapmax", 32'(gap_max), 32'd3);
        check_counts("t2600", 1'b0, 49, 99, 199);

        // Invalid amounts: not a multiple of 100, zero, above the limit
        $display("[TB] step: invalid amounts");
        apply_stimulus(1'b0, 21'd150, 1'b0, 0);
        check_result("t150", 1'b0, 2'b01, 0);
        check_counts("t150", 1'b0, 49, 99, 199);
        apply_stimulus(1'b0, 21'd0, 1'b0, 0);
        check_result("t0", 1'b0, 2'b01, 0);
        apply_stimulus(1'b0, 21'd20100, 1'b0, 0);
        check_result("t20100", 1'b0, 2'b01, 0);
        repeat (4) @(negedge clk);
        check_output("err_held", 32'(a_err), 32'd1);
        check_counts("t20100", 1'b0, 49, 99, 199);

        // Largest legal amount: ten 2000 notes, and err_code cleared by the request
        $display("[TB] step: 20000 boundary");
        apply_stimulus(1'b0, 21'd20000, 1'b0, 0);
        check_result("t20000", 1'b1, 2'b00, 10);
        check_output("t20000_p0", 32'(plog[0]), 32'd2);
        check_output("t20000_p9", 32'(plog[9]), 32'd2);
        check_counts("t20000", 1'b0, 39, 99, 199);

        // Request and refill together: request wins, refill ignored
        $display("[TB] step: request beats refill");
        apply_stimulus(1'b0, 21'd100, 1'b1, 0);
        check_result("t100r", 1'b1, 2'b00, 1);
        check_output("t100r_p0", 32'(plog[0]), 32'd0);
        check_counts("t100r", 1'b0, 39, 99, 198);
        do_refill(1'b0);
        check_counts("refill_a", 1'b0, 50, 100, 200);

        // Small stock: 4000 from one 2000 and four 500s
        $display("[TB] step: 4000 with small stock");
        apply_stimulus(1'b1, 21'd4000, 1'b0, 0);
        check_result("t4000", 1'b1, 2'b00, 5);
        check_output("t4000_p0", 32'(plog[0]), 32'd2);
        check_output("t4000_p1", 32'(plog[1]), 32'd1);
        check_output("t4000_p4", 32'(plog[4]), 32'd1);
        check_output("t4000_gapmin", 32'(gap_min), 32'd3);
        check_output("t4000_gapmax", 32'(gap_max), 32'd3);
        check_counts("t4000", 1'b1, 0, 0, 2);

        // Refill, drain to 2000:0 500:1 100:2, then 1000 is short
        $display("[TB] step: insufficient notes");
        do_refill(1'b1);
        check_counts("refill_b", 1'b1, 1, 4, 2);
        apply_stimulus(1'b1, 21'd3500, 1'b0, 0);
        check_result("t3500", 1'b1, 2'b00, 4);
        check_counts("t3500", 1'b1, 0, 1, 2);
        apply_stimulus(1'b1, 21'd1000, 1'b0, 0);
        check_result("t1000", 1'b0, 2'b10, 0);
        check_counts("t1000", 1'b1, 0, 1, 2);

`ifdef DISP_ABORT_EN
        // Abort in the gap after the first of three notes
        $display("[TB] step: abort in GAP");
        apply_stimulus(1'b0, 21'd2600, 1'b0, 1);
        check_result("tabort", 1'b0, 2'b11, 1);
        check_counts("tabort", 1'b0, 49, 100, 200);
`endif

        // Reset during the second gap of a 2600 request
        $display("[TB] step: reset mid-dispense");
        sel = 1'b0;
        @(negedge clk);
        amount = 21'd2600;
        a_req  = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
        seen  = 0;
        for (int cyc = 0; cyc < 200 && seen < 2; cyc++) begin
            if (a_pulse) seen++;
            if (seen < 2) @(negedge clk);
        end
        check_output("rst_mid_found", 32'(seen), 32'd2);
        @(negedge clk);
        check_output("rst_mid_in_gap", 32'(a_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("rst_mid_busy", 32'(a_busy), 32'd0);
        check_output("rst_mid_pulse", 32'(a_pulse), 32'd0);
        check_counts("rst_mid", 1'b0, 50, 100, 200);
        strobe = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (a_done || a_error || a_pulse || a_busy) strobe = 1;
        end
        check_output("rst_mid_nostrobe", 32'(strobe), 32'd0);
        check_output("rst_mid_err", 32'(a_err), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
